lmsm_sequencer: RTL and testbench

Parametrised multi-register transfer engine that runs load-multiple and store-multiple instructions for the multicycle processor. The main controller sets it going with a register mask and a base address. It then walks the set mask bits in ascending register order and moves one word per transfer between the register file and memory, with a ready handshake on each transfer. It takes over the register-file and memory strobes for the duration and adds three things: ascending or descending addressing, arbitrary register count, and stall tolerance.

---
 rtl/lmsm_sequencer_if.sv | 30 +++
 rtl/lmsm_sequencer.sv | 123 ++++++++++++
 tb/tb_lmsm_sequencer.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/lmsm_sequencer_if.sv
// Register-file and memory bus shared by the LM/SM sequencer and its environment.
interface lmsm_sequencer_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned RA_W   = 3
);
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic              mem_wr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;
  logic [RA_W-1:0]   rf_raddr;
  logic [DATA_W-1:0] rf_rdata;
  logic [RA_W-1:0]   rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic              rf_wen;

  // Sequencer side: drives strobes/addresses, receives read data and ready.
  modport master (
    output mem_addr, mem_rd, mem_wr, mem_wdata, rf_raddr, rf_waddr, rf_wdata, rf_wen,
    input  mem_rdata, mem_ready, rf_rdata
  );

  // Memory / register-file side.
  modport slave (
    input  mem_addr, mem_rd, mem_wr, mem_wdata, rf_raddr, rf_waddr, rf_wdata, rf_wen,
    output mem_rdata, mem_ready, rf_rdata
  );
endinterface

// File: rtl/lmsm_sequencer.sv
// Load-multiple / store-multiple transfer engine: walks the set bits of a
// register mask in ascending order, moving one word per ready handshake.
module lmsm_sequencer #(
  parameter int unsigned NREGS  = 8,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned RA_W   = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              proc_rst,
  input  logic              start,
  input  logic              mode,
  input  logic              addr_dec,
  input  logic [NREGS-1:0]  reg_mask,
  input  logic [ADDR_W-1:0] base_addr,
  lmsm_sequencer_if.master  bus,
  output logic              busy,
  output logic              done,
  output logic [RA_W:0]     xfer_count,
  output logic [ADDR_W-1:0] end_addr
);

  typedef enum logic [1:0] {S_IDLE, S_XFER, S_DONE} state_t;

  state_t            state;
  logic [NREGS-1:0]  pending;
  logic [NREGS-1:0]  pending_clr;
  logic              mode_q;
  logic              dec_q;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] ptr_step;
  logic [RA_W-1:0]   cur;
  logic              in_xfer;
  logic              fire;

  // Lowest set bit of pending selects the current register.
  always_comb begin
    cur = '0;
    for (int unsigned i = NREGS; i > 0; i--) begin
      if (pending[i-1]) cur = RA_W'(i - 1);
    end
  end

  // Clearing the lowest set bit is the same as clearing pending[cur].
  always_comb begin
    pending_clr = pending & (pending - NREGS'(1));
    ptr_step    = dec_q ? (ptr - ADDR_W'(1)) : (ptr + ADDR_W'(1));
    in_xfer     = (state == S_XFER);
    fire        = in_xfer & bus.mem_ready;
  end

  // Bus strobes follow state/pending/mem_ready; data paths are straight mirrors.
  always_comb begin
    bus.mem_addr  = ptr;
    bus.mem_rd    = in_xfer & ~mode_q;
    bus.mem_wr    = in_xfer & mode_q;
    bus.mem_wdata = bus.rf_rdata;
    bus.rf_raddr  = cur;
    bus.rf_waddr  = cur;
    bus.rf_wdata  = bus.mem_rdata;
    bus.rf_wen    = fire & ~mode_q;
  end

  // Sequencer FSM with registered status outputs.
  always_ff @(posedge clk) begin
    if (proc_rst) begin
      state      <= S_IDLE;
      pending    <= '0;
      mode_q     <= 1'b0;
      dec_q      <= 1'b0;
      ptr        <= '0;
      xfer_count <= '0;
      end_addr   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            mode_q     <= mode;
            dec_q      <= addr_dec;
            pending    <= reg_mask;
            ptr        <= base_addr;
            xfer_count <= '0;
            if (reg_mask == '0) begin
              state    <= S_DONE;
              done     <= 1'b1;
              end_addr <= base_addr;
            end else begin
              state <= S_XFER;
              busy  <= 1'b1;
            end
          end
        end
        S_XFER: begin
          if (bus.mem_ready) begin
            pending    <= pending_clr;
            ptr        <= ptr_step;
            xfer_count <= xfer_count + (RA_W+1)'(1);
            // end_addr is loaded on the way into DONE so it is valid with the pulse.
            if (pending_clr == '0) begin
              state    <= S_DONE;
              busy     <= 1'b0;
              done     <= 1'b1;
              end_addr <= ptr_step;
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          done  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lmsm_sequencer.sv
// Directed bench for lmsm_sequencer: 8-register and 16-register instances.
module tb_lmsm_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        proc_rst;
  logic        start, mode, dec, ready;
  logic [7:0]  mask;
  logic [15:0] base;
  logic        start16;
  logic [15:0] mask16;

  logic        busy8, done8;
  logic [3:0]  cnt8;
  logic [15:0] end8;
  logic        busy16, done16;
  logic [4:0]  cnt16;
  logic [15:0] end16;

  int n_assert = 0;
  int n_fail   = 0;

  lmsm_sequencer_if #(.DATA_W(16), .ADDR_W(16), .RA_W(3)) bus8 ();
  lmsm_sequencer_if #(.DATA_W(16), .ADDR_W(16), .RA_W(4)) bus16 ();

  // Memory returns address ^ 5A5A; register file returns A000 | index.
  assign bus8.mem_rdata   = bus8.mem_addr ^ 16'h5A5A;
  assign bus8.mem_ready   = ready;
  assign bus8.rf_rdata    = 16'hA000 | {13'b0, bus8.rf_raddr};
  assign bus16.mem_rdata  = bus16.mem_addr ^ 16'h5A5A;
  assign bus16.mem_ready  = ready;
  assign bus16.rf_rdata   = 16'hA000 | {12'b0, bus16.rf_raddr};

  lmsm_sequencer #(.NREGS(8), .DATA_W(16), .ADDR_W(16), .RA_W(3)) u8 (
    .clk(clk), .proc_rst(proc_rst), .start(start), .mode(mode), .addr_dec(dec),
    .reg_mask(mask), .base_addr(base), .bus(bus8),
    .busy(busy8), .done(done8), .xfer_count(cnt8), .end_addr(end8)
  );

  lmsm_sequencer #(.NREGS(16), .DATA_W(16), .ADDR_W(16), .RA_W(4)) u16 (
    .clk(clk), .proc_rst(proc_rst), .start(start16), .mode(mode), .addr_dec(dec),
    .reg_mask(mask16), .base_addr(base), .bus(bus16),
    .busy(busy16), .done(done16), .xfer_count(cnt16), .end_addr(end16)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to 2 time units after the next rising edge.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    logic [15:0] ea;
    proc_rst = 1'b1; start = 1'b0; mode = 1'b0; dec = 1'b0; ready = 1'b0;
    mask = '0; base = '0; start16 = 1'b0; mask16 = '0;

    // Reset state
    step(); step(); #1;
    chk("rst_mem_rd", bus8.mem_rd, 0);
    chk("rst_mem_wr", bus8.mem_wr, 0);
    chk("rst_rf_wen", bus8.rf_wen, 0);
    chk("rst_busy", busy8, 0);
    chk("rst_done", done8, 0);
    chk("rst_mem_addr", bus8.mem_addr, 0);
    chk("rst_xfer_count", cnt8, 0);
    chk("rst_end_addr", end8, 0);
    step(); proc_rst = 1'b0; #1;

    // LM mask 05 base 0010 increment, no stalls
    step(); start = 1'b1; mode = 1'b0; dec = 1'b0; mask = 8'h05; base = 16'h0010; ready = 1'b1; #1;
    chk("lm1_idle_busy", busy8, 0);
    step(); start = 1'b0; #1;
    chk("lm1_t0_rd", bus8.mem_rd, 1);
    chk("lm1_t0_wr", bus8.mem_wr, 0);
    chk("lm1_t0_addr", bus8.mem_addr, 16'h0010);
    chk("lm1_t0_waddr", bus8.rf_waddr, 0);
    chk("lm1_t0_wen", bus8.rf_wen, 1);
    chk("lm1_t0_wdata", bus8.rf_wdata, 16'h5A4A);
    chk("lm1_t0_busy", busy8, 1);
    chk("lm1_t0_count", cnt8, 0);
    step(); #1;
    chk("lm1_t1_addr", bus8.mem_addr, 16'h0011);
    chk("lm1_t1_waddr", bus8.rf_waddr, 2);
    chk("lm1_t1_wen", bus8.rf_wen, 1);
    chk("lm1_t1_wdata", bus8.rf_wdata, 16'h5A4B);
    chk("lm1_t1_count", cnt8, 1);
    step(); #1;
    chk("lm1_done", done8, 1);
    chk("lm1_done_busy", busy8, 0);
    chk("lm1_done_rd", bus8.mem_rd, 0);
    chk("lm1_done_wen", bus8.rf_wen, 0);
    chk("lm1_count", cnt8, 2);
    chk("lm1_end_addr", end8, 16'h0012);
    step(); #1;
    chk("lm1_after_done", done8, 0);
    chk("lm1_count_hold", cnt8, 2);

    // SM mask 81 base 0100 decrement, two wait cycles per transfer
    step(); start = 1'b1; mode = 1'b1; dec = 1'b1; mask = 8'h81; base = 16'h0100; ready = 1'b0; #1;
    step(); start = 1'b0; #1;
    for (int c = 0; c < 3; c++) begin
      if (c == 2) begin ready = 1'b1; #1; end
      chk("sm_t0_wr", bus8.mem_wr, 1);
      chk("sm_t0_rd", bus8.mem_rd, 0);
      chk("sm_t0_addr", bus8.mem_addr, 16'h0100);
      chk("sm_t0_raddr", bus8.rf_raddr, 0);
      chk("sm_t0_wdata", bus8.mem_wdata, 16'hA000);
      chk("sm_t0_wen", bus8.rf_wen, 0);
      chk("sm_t0_count", cnt8, 0);
      if (c < 2) begin step(); #1; end
    end
    step(); ready = 1'b0; #1;
    for (int c = 0; c < 3; c++) begin
      if (c == 2) begin ready = 1'b1; #1; end
      chk("sm_t1_wr", bus8.mem_wr, 1);
      chk("sm_t1_addr", bus8.mem_addr, 16'h00FF);
      chk("sm_t1_raddr", bus8.rf_raddr, 7);
      chk("sm_t1_wdata", bus8.mem_wdata, 16'hA007);
      chk("sm_t1_count", cnt8, 1);
      if (c < 2) begin step(); #1; end
    end
    step(); #1;
    chk("sm_done", done8, 1);
    chk("sm_done_wr", bus8.mem_wr, 0);
    chk("sm_count", cnt8, 2);
    chk("sm_end_addr", end8, 16'h00FE);

    // Empty mask: done next cycle, no strobes even with mem_ready high
    step(); start = 1'b1; mode = 1'b0; dec = 1'b0; mask = 8'h00; base = 16'h1234; ready = 1'b1; #1;
    step(); start = 1'b0; #1;
    chk("m0_done", done8, 1);
    chk("m0_busy", busy8, 0);
    chk("m0_rd", bus8.mem_rd, 0);
    chk("m0_wr", bus8.mem_wr, 0);
    chk("m0_wen", bus8.rf_wen, 0);
    chk("m0_count", cnt8, 0);
    chk("m0_end_addr", end8, 16'h1234);
    step(); #1;
    chk("m0_after_done", done8, 0);

    // Full mask wrapping past FFFF; stray start during XFER is ignored
    step(); start = 1'b1; mask = 8'hFF; base = 16'hFFFE; #1;
    for (int i = 0; i < 8; i++) begin
      step();
      start = (i == 2);
      if (i == 2) begin mask = 8'h01; base = 16'h0000; end
      #1;
      ea = 16'hFFFE + 16'(i);
      chk("ff_addr", bus8.mem_addr, ea);
      chk("ff_waddr", bus8.rf_waddr, i);
      chk("ff_wen", bus8.rf_wen, 1);
      chk("ff_wdata", bus8.rf_wdata, ea ^ 16'h5A5A);
      chk("ff_count", cnt8, i);
    end
    step(); start = 1'b0; #1;
    chk("ff_done", done8, 1);
    chk("ff_count_final", cnt8, 8);
    chk("ff_end_addr", end8, 16'h0006);
    step(); #1;
    chk("ff_no_second_done_a", done8, 0);
    chk("ff_idle_rd", bus8.mem_rd, 0);
    step(); #1;
    chk("ff_no_second_done_b", done8, 0);
    chk("ff_idle_busy", busy8, 0);

    // Reset in the cycle of the second transfer of an 8-register LM
    step(); start = 1'b1; mode = 1'b0; mask = 8'hFF; base = 16'h0200; #1;
    step(); start = 1'b0; #1;
    chk("rs_t0_addr", bus8.mem_addr, 16'h0200);
    step(); proc_rst = 1'b1; #1;
    chk("rs_t1_addr", bus8.mem_addr, 16'h0201);
    chk("rs_t1_waddr", bus8.rf_waddr, 1);
    step(); proc_rst = 1'b0; #1;
    chk("rs_rd", bus8.mem_rd, 0);
    chk("rs_wen", bus8.rf_wen, 0);
    chk("rs_busy", busy8, 0);
    chk("rs_done", done8, 0);
    chk("rs_addr", bus8.mem_addr, 0);
    chk("rs_count", cnt8, 0);
    chk("rs_end_addr", end8, 0);
    chk("rs_waddr", bus8.rf_waddr, 0);
    step(); #1;
    chk("rs_still_idle_wen", bus8.rf_wen, 0);
    step(); start = 1'b1; mask = 8'h02; base = 16'h0300; #1;
    step(); start = 1'b0; #1;
    chk("rs_new_addr", bus8.mem_addr, 16'h0300);
    chk("rs_new_waddr", bus8.rf_waddr, 1);
    chk("rs_new_wen", bus8.rf_wen, 1);
    chk("rs_new_wdata", bus8.rf_wdata, 16'h595A);
    step(); #1;
    chk("rs_new_done", done8, 1);
    chk("rs_new_count", cnt8, 1);
    chk("rs_new_end", end8, 16'h0301);

    // 16-register instance, mask 8001
    step(); start16 = 1'b1; mask16 = 16'h8001; mode = 1'b0; dec = 1'b0; base = 16'h0040; ready = 1'b1; #1;
    step(); start16 = 1'b0; #1;
    chk("r16_t0_addr", bus16.mem_addr, 16'h0040);
    chk("r16_t0_waddr", bus16.rf_waddr, 0);
    chk("r16_t0_wen", bus16.rf_wen, 1);
    step(); #1;
    chk("r16_t1_addr", bus16.mem_addr, 16'h0041);
    chk("r16_t1_waddr", bus16.rf_waddr, 15);
    chk("r16_t1_wen", bus16.rf_wen, 1);
    step(); #1;
    chk("r16_done", done16, 1);
    chk("r16_count", cnt16, 5'd2);
    chk("r16_end", end16, 16'h0042);
    chk("r16_u8_quiet", done8, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
